// File: rtl/lsu_mem_ctrl.sv
// lsu_mem_ctrl: load/store sequencer between the MEM stage and a single-port
// data-memory bus (req/gnt/rvalid). One request at a time; store data and
// byte enables are lane-aligned, load data is extracted and extended, and
// misaligned accesses or bus timeouts are reported with the completion pulse.
module lsu_mem_ctrl #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 5
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [2:0]  req_funct3,
  output logic        busy,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_misalign,
  output logic        resp_buserr,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       f3_q;
  logic [1:0]       off_q;
  logic             resp_d;

  logic             dec_fault;
  logic [3:0]       dec_be;
  logic [31:0]      dec_wdata;
  logic [31:0]      byte_sh;
  logic [15:0]      half_sel;
  logic [31:0]      load_fmt;
  logic             done;
  logic             timed_out;

  // The stall is held low during reset so every output reads 0 while reset_n is low.
  assign busy = reset_n & req_valid & ~resp_valid;

  // Decode the incoming request: misalignment fault, lane enables and aligned store data.
  always_comb begin
    dec_fault = 1'b0;
    dec_be    = 4'b0000;
    dec_wdata = 32'h0;
    case (req_funct3[1:0])
      2'b00: begin
        dec_be    = 4'b0001 << req_addr[1:0];
        dec_wdata = {24'h0, req_wdata[7:0]} << {req_addr[1:0], 3'b000};
      end
      2'b01: begin
        dec_fault = req_addr[0];
        dec_be    = req_addr[1] ? 4'b1100 : 4'b0011;
        dec_wdata = req_addr[1] ? {req_wdata[15:0], 16'h0} : {16'h0, req_wdata[15:0]};
      end
      2'b10: begin
        dec_fault = (req_addr[1:0] != 2'b00);
        dec_be    = 4'b1111;
        dec_wdata = req_wdata;
      end
      default: dec_fault = 1'b1;
    endcase
    if (req_we && req_funct3[2]) dec_fault = 1'b1;
  end

  // Extract the addressed lane of the returned word and extend it per funct3.
  always_comb begin
    byte_sh  = mem_rdata >> {off_q, 3'b000};
    half_sel = off_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (f3_q)
      3'b000:  load_fmt = {{24{byte_sh[7]}}, byte_sh[7:0]};
      3'b100:  load_fmt = {24'h0, byte_sh[7:0]};
      3'b001:  load_fmt = {{16{half_sel[15]}}, half_sel};
      3'b101:  load_fmt = {16'h0, half_sel};
      default: load_fmt = mem_rdata;
    endcase
  end

  assign done      = ((state == ISSUE) && mem_gnt && mem_rvalid) ||
                     ((state == WAIT) && mem_rvalid);
  assign timed_out = (cnt == CNT_W'(TIMEOUT - 1));

  // Sequencer FSM; all outputs except busy are registered here.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      cnt           <= '0;
      f3_q          <= 3'b000;
      off_q         <= 2'b00;
      resp_d        <= 1'b0;
      resp_valid    <= 1'b0;
      resp_rdata    <= 32'h0;
      resp_misalign <= 1'b0;
      resp_buserr   <= 1'b0;
      mem_req       <= 1'b0;
      mem_we        <= 1'b0;
      mem_addr      <= 32'h0;
      mem_be        <= 4'b0000;
      mem_wdata     <= 32'h0;
    end else begin
      resp_d <= resp_valid;
      case (state)
        IDLE: begin
          if (req_valid && !resp_d) begin
            f3_q  <= req_funct3;
            off_q <= req_addr[1:0];
            if (dec_fault) begin
              state         <= RESP;
              resp_valid    <= 1'b1;
              resp_misalign <= 1'b1;
              resp_rdata    <= 32'h0;
            end else begin
              state     <= ISSUE;
              cnt       <= '0;
              mem_req   <= 1'b1;
              mem_we    <= req_we;
              mem_addr  <= {req_addr[31:2], 2'b00};
              mem_be    <= dec_be;
              mem_wdata <= dec_wdata;
            end
          end
        end
        ISSUE, WAIT: begin
          cnt <= cnt + 1'b1;
          if (done) begin
            state      <= RESP;
            mem_req    <= 1'b0;
            resp_valid <= 1'b1;
            resp_rdata <= mem_we ? 32'h0 : load_fmt;
          end else if (timed_out) begin
            state       <= RESP;
            mem_req     <= 1'b0;
            resp_valid  <= 1'b1;
            resp_buserr <= 1'b1;
            resp_rdata  <= 32'h0;
          end else if ((state == ISSUE) && mem_gnt) begin
            state   <= WAIT;
            mem_req <= 1'b0;
          end
        end
        default: begin
          state         <= IDLE;
          resp_valid    <= 1'b0;
          resp_rdata    <= 32'h0;
          resp_misalign <= 1'b0;
          resp_buserr   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// tb_lsu_mem_ctrl: directed and randomized transactions against a
// cycle-level behavioural model of the load/store sequencer.
module tb_lsu_mem_ctrl;
  localparam int TIMEOUT = 16;

  logic        clk;
  logic        reset_n;
  logic        req_valid;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [2:0]  req_funct3;
  logic        busy;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_misalign;
  logic        resp_buserr;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;

  int checkCount = 0;
  int passCount  = 0;

  lsu_mem_ctrl #(.TIMEOUT(TIMEOUT), .CNT_W(5)) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_funct3(req_funct3),
    .busy(busy), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .resp_misalign(resp_misalign), .resp_buserr(resp_buserr),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_be(mem_be), .mem_wdata(mem_wdata),
    .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed === expected) passCount++;
    else $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
  endtask

  // Reference model: access width from funct3[1:0], alignment rules, lane placement.
  function automatic bit modelFault(input bit we, input logic [2:0] f3, input logic [31:0] addr);
    int size;
    size = 1 << f3[1:0];
    if (f3[1:0] == 2'd3) return 1'b1;
    if (we && f3[2]) return 1'b1;
    return (addr % size) != 0;
  endfunction

  function automatic logic [3:0] modelBe(input logic [2:0] f3, input logic [31:0] addr);
    int size;
    int base;
    size = 1 << f3[1:0];
    base = int'(addr % 4) / size * size;
    return 4'(((1 << size) - 1) << base);
  endfunction

  function automatic logic [31:0] modelWdata(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wdata);
    logic [63:0] mask;
    int size;
    int base;
    size = 1 << f3[1:0];
    base = int'(addr % 4) / size * size;
    mask = (64'd1 << (8 * size)) - 64'd1;
    return 32'((64'(wdata) & mask) << (8 * base));
  endfunction

  function automatic logic [31:0] modelRdata(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] rdata);
    logic [31:0] sh;
    sh = rdata >> (8 * int'(addr % 4));
    case (f3)
      3'b000:  return 32'($signed(sh[7:0]));
      3'b100:  return {24'h0, sh[7:0]};
      3'b001:  return 32'($signed(sh[15:0]));
      3'b101:  return {16'h0, sh[15:0]};
      default: return rdata;
    endcase
  endfunction

  // One full transaction: grant g cycles after the first ISSUE cycle, rvalid r
  // cycles after grant (r < 0 means never). Outputs sampled on the falling edge.
  task automatic applyStimulus(input bit we, input logic [2:0] f3, input logic [31:0] addr,
                               input logic [31:0] wdata, input logic [31:0] rdata,
                               input int g, input int r);
    bit fault;
    bit expBuserr;
    bit gotResp;
    int expCycle;
    int reqLast;
    logic [31:0] expData;
    @(negedge clk);
    req_valid  = 1'b1;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wdata;
    mem_rdata  = rdata;
    mem_gnt    = 1'b0;
    mem_rvalid = 1'b0;
    fault      = modelFault(we, f3, addr);
    expBuserr  = 1'b0;
    if (fault) begin
      expCycle = 1;
      reqLast  = 0;
    end else begin
      reqLast = (1 + g < TIMEOUT) ? 1 + g : TIMEOUT;
      if (r >= 0 && 1 + g + r <= TIMEOUT) expCycle = 2 + g + r;
      else begin
        expCycle  = 1 + TIMEOUT;
        expBuserr = 1'b1;
      end
    end
    expData = (fault || we || expBuserr) ? 32'h0 : modelRdata(f3, addr, rdata);
    gotResp = 1'b0;
    for (int c = 1; c <= 60 && !gotResp; c++) begin
      @(negedge clk);
      checkOutput("mem_req", 32'(mem_req), 32'(!fault && c <= reqLast));
      if (mem_req) begin
        checkOutput("mem_we", 32'(mem_we), 32'(we));
        checkOutput("mem_addr", mem_addr, addr & 32'hFFFF_FFFC);
        checkOutput("mem_be", 32'(mem_be), 32'(modelBe(f3, addr)));
        checkOutput("mem_wdata", mem_wdata, modelWdata(f3, addr, wdata));
      end
      mem_gnt    = !fault && (c == 1 + g);
      mem_rvalid = !fault && (r >= 0) && (c == 1 + g + r);
      if (resp_valid) begin
        gotResp = 1'b1;
        checkOutput("resp_cycle", 32'(c), 32'(expCycle));
        checkOutput("resp_rdata", resp_rdata, expData);
        checkOutput("resp_misalign", 32'(resp_misalign), 32'(fault));
        checkOutput("resp_buserr", 32'(resp_buserr), 32'(expBuserr));
        checkOutput("busy_resp", 32'(busy), 32'h0);
      end else begin
        checkOutput("busy_wait", 32'(busy), 32'h1);
      end
    end
    if (!gotResp) checkOutput("resp_seen", 32'h0, 32'h1);
    mem_gnt    = 1'b0;
    mem_rvalid = 1'b0;
    @(negedge clk);
    checkOutput("no_reissue_req", 32'(mem_req), 32'h0);
    checkOutput("resp_one_cycle", 32'(resp_valid), 32'h0);
    req_valid = 1'b0;
    @(negedge clk);
    checkOutput("idle_req", 32'(mem_req), 32'h0);
    checkOutput("idle_resp", 32'(resp_valid), 32'h0);
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_busy"}, 32'(busy), 32'h0);
    checkOutput({tag, "_resp_valid"}, 32'(resp_valid), 32'h0);
    checkOutput({tag, "_resp_rdata"}, resp_rdata, 32'h0);
    checkOutput({tag, "_flags"}, 32'({resp_misalign, resp_buserr}), 32'h0);
    checkOutput({tag, "_mem_req"}, 32'({mem_req, mem_we}), 32'h0);
    checkOutput({tag, "_mem_addr"}, mem_addr, 32'h0);
    checkOutput({tag, "_mem_be"}, 32'(mem_be), 32'h0);
    checkOutput({tag, "_mem_wdata"}, mem_wdata, 32'h0);
  endtask

  initial begin
    reset_n    = 1'b0;
    req_valid  = 1'b0;
    req_we     = 1'b0;
    req_addr   = 32'h0;
    req_wdata  = 32'h0;
    req_funct3 = 3'b000;
    mem_gnt    = 1'b0;
    mem_rvalid = 1'b0;
    mem_rdata  = 32'h0;
    repeat (3) @(negedge clk);
    checkAllZero("reset");
    reset_n = 1'b1;
    @(negedge clk);

    applyStimulus(1'b1, 3'b000, 32'h0000_1003, 32'hAABB_CCDD, 32'h0, 0, 1);
    applyStimulus(1'b0, 3'b001, 32'h0000_2002, 32'h0, 32'h8001_1234, 0, 1);
    applyStimulus(1'b0, 3'b101, 32'h0000_2002, 32'h0, 32'h8001_1234, 1, 0);
    applyStimulus(1'b0, 3'b010, 32'h0000_0006, 32'h0, 32'h1234_5678, 0, 1);
    applyStimulus(1'b1, 3'b110, 32'h0000_0008, 32'h5555_AAAA, 32'h0, 0, 1);
    applyStimulus(1'b0, 3'b100, 32'h0000_0011, 32'h0, 32'h0000_F000, 3, 2);
    applyStimulus(1'b0, 3'b010, 32'h0000_0100, 32'h0, 32'hCAFE_F00D, 0, -1);

    // A late rvalid after the timeout must not produce a response or bus request.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("late_rvalid_resp", 32'(resp_valid), 32'h0);
      checkOutput("late_rvalid_req", 32'(mem_req), 32'h0);
      mem_rvalid = 1'b1;
    end
    @(negedge clk);
    mem_rvalid = 1'b0;
    checkOutput("late_rvalid_resp_end", 32'(resp_valid), 32'h0);

    // Reset asserted while the transaction waits for rvalid.
    @(negedge clk);
    req_valid  = 1'b1;
    req_we     = 1'b0;
    req_funct3 = 3'b010;
    req_addr   = 32'h0000_0040;
    @(negedge clk);
    checkOutput("pre_reset_req", 32'(mem_req), 32'h1);
    mem_gnt = 1'b1;
    @(negedge clk);
    mem_gnt = 1'b0;
    checkOutput("pre_reset_wait", 32'(mem_req), 32'h0);
    #2 reset_n = 1'b0;
    #1 checkAllZero("async_reset");
    req_valid = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    applyStimulus(1'b1, 3'b010, 32'h0000_0200, 32'h1357_9BDF, 32'h0, 1, 1);

    for (int i = 0; i < 40; i++) begin
      int g;
      int r;
      g = ($urandom_range(0, 9) == 0) ? 20 : int'($urandom_range(0, 4));
      r = ($urandom_range(0, 9) == 0) ? -1 : int'($urandom_range(0, 3));
      applyStimulus(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), $urandom,
                    $urandom, $urandom, g, r);
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/lsu_mem_ctrl.md
Name: lsu_mem_ctrl

Overview:
- Load/store sequencer between the MEM pipeline stage and a single-port data-memory bus using a req/gnt/rvalid handshake.
- Latches one load or store request, aligns the store data and byte enables to the addressed lanes, and issues one word-aligned bus transaction.
- Waits for completion, then sign- or zero-extends the returned load data and reports completion, a misalignment fault or a bus timeout to the core.

Parameters:
- TIMEOUT, 16, maximum cycles spent in ISSUE plus WAIT before a bus error is reported; must be >= 2.
- CNT_W, 5, width of the timeout counter; must satisfy 2^CNT_W > TIMEOUT.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- reset_n  in  1  asynchronous active-low reset.
- req_valid  in  1  core request; fields below stay stable until resp_valid.
- req_we  in  1  1 = store, 0 = load.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-justified.
- req_funct3  in  3  RISC-V width/sign code.
- busy  out  1  stall to the core.
- resp_valid  out  1  one-cycle completion pulse.
- resp_rdata  out  32  extended load result; 0 for stores and faults.
- resp_misalign  out  1  misaligned-access fault, qualified by resp_valid.
- resp_buserr  out  1  timeout fault, qualified by resp_valid.
- mem_req  out  1  bus request.
- mem_we  out  1  bus write.
- mem_addr  out  32  {req_addr[31:2], 2'b00}.
- mem_be  out  4  byte lane enables.
- mem_wdata  out  32  lane-aligned store data.
- mem_gnt  in  1  bus accepted the request this cycle.
- mem_rvalid  in  1  transaction complete; mem_rdata valid.
- mem_rdata  in  32  read word.

Behaviour:
- Reset: while reset_n is low, state = IDLE and every output and register is 0. Reset is asynchronous, so assertion mid-transaction aborts it immediately with no response.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE, req_valid = 1 and resp_valid was 0 in the previous cycle: latch all request fields and decode them.
  - Fault request: go to RESP with resp_misalign = 1. No bus activity.
  - Any other request: go to ISSUE.
- What counts as a fault:
  - funct3 = 001 or 101 with addr[0] = 1.
  - funct3 = 010 or 110 with addr[1:0] != 0.
  - funct3 = 011 or 111.
  - A store with funct3[2] = 1.
- Lane encoding:
  - Byte: mem_be = 4'b0001 << addr[1:0]; mem_wdata = wdata[7:0] placed in that lane, all other bits 0.
  - Half: mem_be = 0011 (addr[1] = 0) or 1100 (addr[1] = 1); mem_wdata = wdata[15:0] placed in the matching half, other bits 0.
  - Word: mem_be = 1111; mem_wdata = wdata.
  - For loads, mem_be is driven identically to stores.
- ISSUE:
  - mem_req = 1; mem_we/addr/be/wdata are registered and stable.
  - On mem_gnt, drop mem_req the next cycle and go to WAIT.
  - If mem_gnt and mem_rvalid are both 1 in the same cycle, capture the data and go directly to RESP.
- WAIT: on mem_rvalid, capture mem_rdata, format it, go to RESP.
- Load formatting (selected lane, extended to 32 bits):
  - 000: sign-extend byte.
  - 100: zero-extend byte.
  - 001: sign-extend half.
  - 101: zero-extend half.
  - 010 and 110: full word.
- Timeout:
  - The counter clears on IDLE -> ISSUE and increments every cycle in ISSUE or WAIT.
  - When it reaches TIMEOUT without completion: drop mem_req, go to RESP with resp_buserr = 1 and resp_rdata = 0.
  - A late mem_rvalid arriving in IDLE or RESP is ignored.
- RESP: resp_valid = 1 for exactly one cycle, then IDLE. The request fields are not re-sampled in the cycle immediately after RESP, so a held req_valid is not issued twice.
- busy = req_valid & ~resp_valid. This is the only combinational output; all other outputs are registered.
- Latency:
  - Zero-wait bus (gnt in the first ISSUE cycle, rvalid one cycle later): resp_valid appears 3 cycles after req_valid is sampled.
  - Fault: resp_valid 1 cycle after req_valid is sampled.

Test Plan:
- SB addr 0x1003, wdata 0xAABBCCDD, immediate gnt -> mem_addr 0x1000, mem_be 1000, mem_wdata 0xDD000000, resp_valid 3 cycles after request, resp_rdata 0.
- LH addr 0x2002, mem_rdata 0x8001_1234 -> resp_rdata 0xFFFF8001. Same access as LHU -> 0x00008001.
- LW addr 0x0006 -> no mem_req, resp_valid + resp_misalign 1 cycle after request. SW with funct3 110 -> misalign fault.
- gnt delayed 3 cycles, rvalid 2 cycles later, LBU addr 0x11, mem_rdata 0x0000F000 -> mem_req held stable 4 cycles, resp_rdata 0x000000F0.
- TIMEOUT = 16, gnt given but rvalid never asserted -> resp_buserr = 1 with resp_valid at cycle 16 after ISSUE entry; a later rvalid has no effect.
- reset_n low during WAIT -> all outputs 0 asynchronously, state IDLE. After release, a fresh SW completes normally with mem_be 1111.
